// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
//
// Shares the single data-memory / peripheral bus between the pipeline MEM
// stage (CPU) and a DMA engine. The CPU has default priority. The DMA engine
// gets multi-beat bursts of up to MAX_BURST beats, and a waiting DMA request
// preempts the CPU once it has waited STARVE_LIMIT cycles. Grants are
// combinational from the registered arbitration state and the current
// requests, so every bus beat completes in the cycle it is granted.
//
// Handshake: a requester holds req (and its wr/addr/wdata/last) steady until
// the cycle it is granted; the beat is transferred in exactly that cycle
// (cpu: cpu_req & ~cpu_stall, dma: dma_gnt) and read data is returned
// combinationally in the same cycle. A held request is never issued twice.
//
// Optional feature (macro DBUS_PROT_EN): DMA beats aimed at peripheral/UART
// space (dma_addr[31:30] != 2'b00) are acknowledged but blocked from the bus,
// a one-cycle dma_err pulse follows, and any burst in progress is ended.
// Without the macro no address check is done and dma_err is tied 0.
//
// Ports:
//   sysclk, reset          clock (rising edge), async active-high reset
//   cpu_req/wr/addr/wdata  MEM-stage request; cpu_rdata, cpu_stall back
//   dma_req/wr/addr/wdata  DMA beat request, dma_last marks final beat;
//                          dma_gnt, dma_rdata, dma_err back
//   bus_rd/wr/addr/wdata   to the slaves; bus_rdata is the OR of slave data
//   dbg_state              current arbitration state (0 = CPU, 1 = DMA)
// ---------------------------------------------------------------------------
module dbus_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    // CPU (MEM stage)
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    // DMA engine
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    // Shared bus
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    // Debug
    output logic        dbg_state
);

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_state_t;

    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    arb_state_t state;
    logic [7:0] beat_cnt;
    logic [7:0] wait_cnt;

    logic gcpu;
    logic gdma;
    logic starved;
    logic dma_blocked;

    assign starved   = (wait_cnt == STARVE_MAX);
    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // Grant. Gated by reset so the bus is idle while reset is held, even if
    // the requesters keep their requests up.
    // -----------------------------------------------------------------------
    always_comb begin
        gcpu = 1'b0;
        gdma = 1'b0;
        if (!reset) begin
            case (state)
                ARB_DMA: begin
                    gdma = dma_req;
                    gcpu = cpu_req & ~dma_req;
                end
                default: begin
                    if (starved) begin
                        gdma = dma_req;
                        gcpu = cpu_req & ~dma_req;
                    end else begin
                        gcpu = cpu_req;
                        gdma = dma_req & ~cpu_req;
                    end
                end
            endcase
        end
    end

`ifdef DBUS_PROT_EN
    // Peripheral/UART space lives at dma_addr[31:30] != 0; DMA may not touch it.
    assign dma_blocked = gdma & (dma_addr[31:30] != 2'b00);
`else
    assign dma_blocked = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Bus mux and returned data
    // -----------------------------------------------------------------------
    always_comb begin
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        if (gcpu) begin
            bus_rd    = ~cpu_wr;
            bus_wr    = cpu_wr;
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
        end else if (gdma) begin
            // A blocked beat still presents its address but never strobes.
            bus_rd    = ~dma_wr & ~dma_blocked;
            bus_wr    = dma_wr & ~dma_blocked;
            bus_addr  = dma_addr;
            bus_wdata = dma_wdata;
        end
    end

    assign cpu_rdata = gcpu ? bus_rdata : 32'h0;
    assign dma_rdata = (gdma & ~dma_blocked) ? bus_rdata : 32'h0;
    assign cpu_stall = cpu_req & ~gcpu;
    assign dma_gnt   = gdma;

    // -----------------------------------------------------------------------
    // Arbitration state, burst beat counter and DMA wait (starvation) counter
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= ARB_CPU;
            beat_cnt <= 8'd0;
            wait_cnt <= 8'd0;
        end else begin
            if (gdma || !dma_req) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != STARVE_MAX) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            case (state)
                ARB_DMA: begin
                    // In ARB_DMA gdma follows dma_req, so a dropped request
                    // means the engine abandoned the burst.
                    if (!dma_req || dma_last || dma_blocked ||
                        (beat_cnt + 8'd1 == BURST_MAX)) begin
                        state    <= ARB_CPU;
                        beat_cnt <= 8'd0;
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    // Single-beat transfers and MAX_BURST == 1 stay in ARB_CPU.
                    if (gdma && !dma_last && !dma_blocked && (BURST_MAX > 8'd1)) begin
                        state    <= ARB_DMA;
                        beat_cnt <= 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef DBUS_PROT_EN
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            dma_err <= 1'b0;
        end else begin
            dma_err <= dma_blocked;
        end
    end
`else
    assign dma_err = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dbus_arbiter
//
// Directed bench for dbus_arbiter: a table of single-cycle vectors for the
// grant/bus mux, then hand-written multi-cycle sequences for starvation,
// bursts, burst cap, reset mid-burst and the protection option.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_dbus_arbiter;

  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 16;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr, dma_last, dma_gnt, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        dbg_state;

  dbus_arbiter #(
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_wr    (dma_wr),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_last  (dma_last),
    .dma_gnt   (dma_gnt),
    .dma_rdata (dma_rdata),
    .dma_err   (dma_err),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = req;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic dma_drive(input logic req, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic last);
    dma_req   = req;
    dma_wr    = wr;
    dma_addr  = addr;
    dma_wdata = wdata;
    dma_last  = last;
  endtask

  task automatic idle_all();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus_rdata = 32'h0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        c_req;
    logic        c_wr;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_gnt;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_crd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int idx;
    int cyc;
    int got;
    logic cpu_pending;

    // Every vector starts in ARB_CPU with wait_cnt = 0; DMA beats are single
    // (dma_last = 1) so the state never leaves ARB_CPU.
    vecs[0] = '{0,0,32'h0,32'h0,        0,0,32'h0,32'h0,               32'hDEADBEEF, 0,0,0,0, 32'h0,32'h0,32'h0,32'h0};
    vecs[1] = '{1,0,32'h10,32'h1234,    0,0,32'h0,32'h0,               32'h0000A5A5, 0,0,1,0, 32'h10,32'h1234,32'hA5A5,32'h0};
    vecs[2] = '{1,1,32'h20,32'hCAFE,    0,0,32'h0,32'h0,               32'h00000077, 0,0,0,1, 32'h20,32'hCAFE,32'h77,32'h0};
    vecs[3] = '{0,0,32'h0,32'h0,        1,0,32'h200,32'h55,            32'h00000099, 0,1,1,0, 32'h200,32'h55,32'h0,32'h99};
    vecs[4] = '{0,0,32'h0,32'h0,        1,1,32'h204,32'h66,            32'h00000001, 0,1,0,1, 32'h204,32'h66,32'h0,32'h1};
    vecs[5] = '{1,0,32'h30,32'hAB,      1,1,32'h300,32'hCD,            32'h00000042, 0,0,1,0, 32'h30,32'hAB,32'h42,32'h0};
    vecs[6] = '{1,1,32'h34,32'hBB,      1,0,32'h304,32'hEE,            32'h00000043, 0,0,0,1, 32'h34,32'hBB,32'h43,32'h0};
    vecs[7] = '{0,0,32'h0,32'h0,        1,1,32'h3FFFFFFC,32'h7,        32'h00000008, 0,1,0,1, 32'h3FFFFFFC,32'h7,32'h0,32'h8};

    // ---------------- reset ----------------
    reset = 1'b1;
    idle_all();
    bus_rdata = 32'h5555AAAA;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_bus_rd", bus_rd, 1'b0);
    check("rst_bus_wr", bus_wr, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dma_rdata", dma_rdata, 32'h0);
    check("rst_state", dbg_state, 1'b0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    @(negedge sysclk);
    check("idle_stall", cpu_stall, 1'b0);
    check("idle_gnt", dma_gnt, 1'b0);
    check("idle_err", dma_err, 1'b0);
    check("idle_cpu_rdata", cpu_rdata, 32'h0);
    check("idle_bus_wdata", bus_wdata, 32'h0);
    next_cycle();

    // ---------------- table-driven grant / mux vectors ----------------
    for (int i = 0; i < 8; i++) begin
      cpu_drive(vecs[i].c_req, vecs[i].c_wr, vecs[i].c_addr, vecs[i].c_wdata);
      dma_drive(vecs[i].d_req, vecs[i].d_wr, vecs[i].d_addr, vecs[i].d_wdata, 1'b1);
      bus_rdata = vecs[i].rdata;
      @(negedge sysclk);
      check($sformatf("v%0d_stall", i), cpu_stall, vecs[i].e_stall);
      check($sformatf("v%0d_gnt", i), dma_gnt, vecs[i].e_gnt);
      check($sformatf("v%0d_rd", i), bus_rd, vecs[i].e_rd);
      check($sformatf("v%0d_wr", i), bus_wr, vecs[i].e_wr);
      check($sformatf("v%0d_addr", i), bus_addr, vecs[i].e_addr);
      check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      check($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].e_drd);
      next_cycle();
      idle_all();
      @(negedge sysclk);
      check($sformatf("v%0d_state", i), dbg_state, 1'b0);
      next_cycle();
    end

    // ---------------- CPU priority vs starvation ----------------
    // Both request every cycle; DMA waits 16 cycles, takes cycle 17, then
    // the CPU wins again in cycle 18.
    cpu_drive(1'b1, 1'b0, 32'h40, 32'h0);
    dma_drive(1'b1, 1'b1, 32'h400, 32'h9, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      @(negedge sysclk);
      check($sformatf("starve_c%0d_stall", c), cpu_stall, (c == 17) ? 1'b1 : 1'b0);
      check($sformatf("starve_c%0d_gnt", c), dma_gnt, (c == 17) ? 1'b1 : 1'b0);
      next_cycle();
    end
    check("starve_state", dbg_state, 1'b0);
    idle_all();
    next_cycle();

    // ---------------- 8-beat DMA burst with CPU raised at beat 3 ----------------
    exp_q.delete();
    for (int b = 1; b <= 8; b++) exp_q.push_back(32'(b * 32'h11));
    for (int b = 1; b <= 8; b++) begin
      dma_drive(1'b1, 1'b1, 32'h100 + 32'((b - 1) * 4), 32'(b * 32'h11), b == 8);
      if (b >= 3) cpu_drive(1'b1, 1'b0, 32'h500, 32'h0);
      @(negedge sysclk);
      check($sformatf("burst_b%0d_gnt", b), dma_gnt, 1'b1);
      check($sformatf("burst_b%0d_wr", b), bus_wr, 1'b1);
      check($sformatf("burst_b%0d_addr", b), bus_addr, 32'h100 + 32'((b - 1) * 4));
      check($sformatf("burst_b%0d_wdata", b), bus_wdata, exp_q.pop_front());
      check($sformatf("burst_b%0d_stall", b), cpu_stall, (b >= 3) ? 1'b1 : 1'b0);
      check($sformatf("burst_b%0d_state", b), dbg_state, (b >= 2) ? 1'b1 : 1'b0);
      next_cycle();
    end
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    bus_rdata = 32'h12345678;
    @(negedge sysclk);
    check("burst_cpu_stall", cpu_stall, 1'b0);
    check("burst_cpu_rd", bus_rd, 1'b1);
    check("burst_cpu_addr", bus_addr, 32'h500);
    check("burst_cpu_rdata", cpu_rdata, 32'h12345678);
    check("burst_state_back", dbg_state, 1'b0);
    check("burst_q_empty", 32'(exp_q.size()), 32'h0);
    next_cycle();
    idle_all();
    next_cycle();

    // ---------------- burst cap: 12 beats, MAX_BURST = 8 ----------------
    // Grant order expected: 8 DMA beats, 1 CPU slot, 4 DMA beats.
    // Codes: 1 = DMA beat, 2 = CPU access.
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'd1);
    idx = 0;
    cyc = 0;
    cpu_pending = 1'b0;
    while (idx < 12 && cyc < 40) begin
      dma_drive(1'b1, 1'b1, 32'h600 + 32'(idx * 4), 32'(idx + 1), idx == 11);
      cpu_drive(cpu_pending, 1'b0, 32'h700, 32'h0);
      @(negedge sysclk);
      got = dma_gnt ? 1 : ((cpu_req && !cpu_stall) ? 2 : 0);
      if (got != 0) begin
        if (exp_q.size() == 0) check("cap_extra_grant", 32'(got), 32'h0);
        else check($sformatf("cap_grant_c%0d", cyc), 32'(got), exp_q.pop_front());
      end
      next_cycle();
      if (got == 1) idx++;
      if (got == 2) cpu_pending = 1'b0;
      if (got == 1 && idx == 1) cpu_pending = 1'b1;
      cyc++;
    end
    check("cap_beats_done", 32'(idx), 32'd12);
    check("cap_q_empty", 32'(exp_q.size()), 32'h0);
    idle_all();
    next_cycle();

    // ---------------- reset mid-burst ----------------
    dma_drive(1'b1, 1'b1, 32'h800, 32'hA1, 1'b0);
    next_cycle();
    dma_drive(1'b1, 1'b1, 32'h804, 32'hA2, 1'b0);
    @(negedge sysclk);
    check("rmid_state_dma", dbg_state, 1'b1);
    next_cycle();
    dma_drive(1'b1, 1'b1, 32'h808, 32'hA3, 1'b0);
    cpu_drive(1'b1, 1'b0, 32'h900, 32'h0);
    bus_rdata = 32'hFEEDF00D;
    #2;
    reset = 1'b1;
    @(negedge sysclk);
    check("rmid_bus_rd", bus_rd, 1'b0);
    check("rmid_bus_wr", bus_wr, 1'b0);
    check("rmid_bus_addr", bus_addr, 32'h0);
    check("rmid_bus_wdata", bus_wdata, 32'h0);
    check("rmid_gnt", dma_gnt, 1'b0);
    check("rmid_dma_rdata", dma_rdata, 32'h0);
    check("rmid_state", dbg_state, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge sysclk);
    check("rmid_after_stall", cpu_stall, 1'b0);
    check("rmid_after_gnt", dma_gnt, 1'b0);
    check("rmid_after_addr", bus_addr, 32'h900);
    check("rmid_after_rdata", cpu_rdata, 32'hFEEDF00D);
    check("rmid_after_state", dbg_state, 1'b0);
    next_cycle();
    idle_all();
    next_cycle();

    // ---------------- DMA access to peripheral space ----------------
    dma_drive(1'b1, 1'b1, 32'h40000010, 32'hF00D, 1'b1);
    @(negedge sysclk);
    check("prot_gnt", dma_gnt, 1'b1);
    check("prot_err_same", dma_err, 1'b0);
`ifdef DBUS_PROT_EN
    check("prot_bus_wr", bus_wr, 1'b0);
`else
    check("prot_bus_wr", bus_wr, 1'b1);
    check("prot_bus_addr", bus_addr, 32'h40000010);
`endif
    next_cycle();
    idle_all();
    @(negedge sysclk);
`ifdef DBUS_PROT_EN
    check("prot_err_next", dma_err, 1'b1);
`else
    check("prot_err_next", dma_err, 1'b0);
`endif
    next_cycle();
    dma_drive(1'b1, 1'b0, 32'h80000020, 32'h0, 1'b1);
    bus_rdata = 32'h0BADCAFE;
    @(negedge sysclk);
    check("prot_rd_gnt", dma_gnt, 1'b1);
`ifdef DBUS_PROT_EN
    check("prot_rd_bus_rd", bus_rd, 1'b0);
    check("prot_rd_rdata", dma_rdata, 32'h0);
`else
    check("prot_rd_bus_rd", bus_rd, 1'b1);
    check("prot_rd_rdata", dma_rdata, 32'h0BADCAFE);
`endif
    next_cycle();
    idle_all();
    @(negedge sysclk);
`ifdef DBUS_PROT_EN
    check("prot_rd_err", dma_err, 1'b1);
`else
    check("prot_rd_err", dma_err, 1'b0);
`endif
    next_cycle();
    @(negedge sysclk);
    check("prot_err_clear", dma_err, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-memory/peripheral bus (DataMem, Peripheral, UARTUnit, all addressed by the MEM-stage address) between two requesters: the pipeline MEM stage (CPU) and a DMA engine (UART receive buffer fill / block copy).
- The CPU has default priority. DMA gets bursts and an anti-starvation slot.
- When the CPU loses arbitration, the block raises cpu_stall so the pipeline freezes IF/ID/EX/MEM.
- Every bus beat completes in the cycle it is granted; read data is combinational from the bus.

Parameters:
- MAX_BURST, 8: maximum consecutive DMA beats per burst (1..255).
- STARVE_LIMIT, 16: cycles a DMA request may wait before it preempts the CPU (1..255).

Ports:
- sysclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM-stage access request (MemRd|MemWr).
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid in the granted cycle.
- cpu_stall  out  1  CPU request not granted this cycle.
- dma_req  in  1  DMA beat request.
- dma_wr  in  1  1 = write.
- dma_addr  in  32  byte address.
- dma_wdata  in  32  write data.
- dma_last  in  1  current beat is the last of the burst.
- dma_gnt  out  1  DMA beat accepted this cycle.
- dma_rdata  out  32  read data, valid when dma_gnt is 1.
- dma_err  out  1  protection fault pulse (DBUS_PROT_EN only; otherwise tied 0).
- bus_rd  out  1  to slaves.
- bus_wr  out  1  to slaves.
- bus_addr  out  32  to slaves.
- bus_wdata  out  32  to slaves.
- bus_rdata  in  32  OR of slave read data.

Behaviour:
- **State register:** ARB_CPU (default) or ARB_DMA. Registers: state, beat_cnt[7:0], wait_cnt[7:0].
- **Reset:** state = ARB_CPU, beat_cnt = 0, wait_cnt = 0. With no requests all outputs are 0 (cpu_rdata and dma_rdata are forced to 0 when not granted).
- **Grant:** combinational from registered state and current requests, giving zero-latency grant. At most one of gcpu/gdma is 1 per cycle.
  - ARB_CPU, wait_cnt < STARVE_LIMIT: gcpu = cpu_req; gdma = dma_req & ~cpu_req.
  - ARB_CPU, wait_cnt == STARVE_LIMIT: gdma = dma_req (preempt); gcpu = cpu_req & ~dma_req.
  - ARB_DMA: gdma = dma_req; gcpu = cpu_req & ~dma_req.
- **Bus mux:**
  - gcpu: bus driven from cpu_*, bus_rd = ~cpu_wr, bus_wr = cpu_wr.
  - gdma: bus driven from dma_*.
  - Neither: bus_rd = bus_wr = 0, bus_addr and bus_wdata = 0.
  - cpu_rdata = gcpu ? bus_rdata : 0; dma_rdata = gdma ? bus_rdata : 0.
- **Outputs:** cpu_stall = cpu_req & ~gcpu; dma_gnt = gdma.
- **wait_cnt:**
  - Clears on any gdma or when dma_req = 0.
  - Otherwise increments when dma_req & ~gdma, saturating at STARVE_LIMIT.
- **Transitions (clocked):**
  - ARB_CPU → ARB_DMA when gdma & ~dma_last & MAX_BURST > 1; beat_cnt <= 1.
  - ARB_DMA, gdma: beat_cnt++. Return to ARB_CPU when dma_last or beat_cnt+1 == MAX_BURST; beat_cnt <= 0.
  - ARB_DMA, ~dma_req: DMA abandoned the burst; return to ARB_CPU, beat_cnt <= 0.
- **Boundary conditions:**
  - Simultaneous cpu_req and dma_req in ARB_CPU without starvation: CPU wins, DMA waits.
  - A single-beat DMA (dma_last on the first beat) never enters ARB_DMA.
  - MAX_BURST = 1 never enters ARB_DMA.
  - CPU stalled across a burst: its request inputs are held by the pipeline and the beat completes on the first gcpu cycle. No CPU transaction is issued twice.
  - Reset asserted mid-burst: immediate return to ARB_CPU, counters 0, bus idle. A partial burst is not resumed.

Optional Feature:
- Macro: DBUS_PROT_EN.
- **Defined:** a DMA beat whose dma_addr[31:30] != 2'b00 (peripheral/UART space) is granted (dma_gnt = 1, so the engine does not hang) but blocked:
  - bus_rd and bus_wr are held 0 and dma_rdata = 0.
  - dma_err is registered high for exactly one cycle after the beat.
  - The burst is forced to end: state <= ARB_CPU.
- **Undefined:** no address check; dma_err is tied 0.

Test Plan:
- **Reset mid-burst:** reset pulse in the middle of a 4-beat DMA burst → all bus outputs 0 during reset. After release the CPU gets the first grant and state = ARB_CPU.
- **CPU priority:** cpu_req = dma_req = 1 continuously with STARVE_LIMIT = 16, dma_last = 1 on every beat → CPU granted for 16 cycles. Cycle 17: dma_gnt = 1, cpu_stall = 1. Cycle 18: CPU granted again.
- **DMA burst:** CPU idle, 8-beat DMA writes of 0x11..0x88 to 0x100..0x11C with dma_last on beat 8 → 8 consecutive dma_gnt. A cpu_req raised at beat 3 sees cpu_stall = 1 until the cycle after beat 8, then completes its read with the correct bus_rdata.
- **Burst cap:** 12-beat DMA with MAX_BURST = 8 → 8 beats, one CPU slot when cpu_req = 1, then the remaining 4 beats.
- **Protection fault:** DBUS_PROT_EN defined, DMA write to 0x40000010 → dma_gnt = 1, bus_wr = 0, dma_err = 1 on the next cycle only. Same stimulus without the macro → bus_wr = 1 and bus_addr = 0x40000010.
